traffic_light_timed: RTL
========================

// Module: traffic_light_timed
// PURPOSE
//  Two-street intersection controller with timed phases. It replaces the untimed 4-state sinaleira FSM.
//  Adds tick-timed green/yellow phases with min/max green, all-red clearance and an optional pedestrian walk phase.
//  Sits between the street sensor inputs and the lamp drivers. All timing counts tick pulses from a shared prescaler.
// PARAMETERS
//  CNT_W        8   phase counter width; every *_TICKS value must be <= 2**CNT_W-1
//  GREEN_MIN    4   min green ticks per street
//  GREEN_MAX    12  max green ticks per street (>= GREEN_MIN)
//  YELLOW_TICKS 2   yellow duration in ticks (>= 1)
//  ALLRED_TICKS 1   all-red clearance in ticks (>= 1)
//  PED_TICKS    6   walk duration in ticks (used only with TLC_PED_EN)
// PORTS
//  clk       in   1  clock; single clock domain
//  rst       in   1  synchronous active-high reset
//  tick      in   1  1-cycle timing strobe; all phase timing advances only on tick=1
//  TA        in   1  traffic present on street A
//  TB        in   1  traffic present on street B
//  ped_req   in   1  pedestrian button, level or pulse
//  LA        out  2  lamp A: 00 green, 01 yellow, 10 red (11 never driven)
//  LB        out  2  lamp B, same encoding as LA
//  ped_walk  out  1  walk lamp
//  phase     out  3  current state code, for debug
// BEHAVIOUR
//  - Clock/reset: one clock; reset is synchronous and active-high.
//  - State register and phase counter cnt are the only timing state.
//  - LA, LB and ped_walk are decoded combinationally from the state register (Moore).
//  - Reset: state=A_GRN(0), cnt=0, ped_pend=0, so LA=00, LB=10, ped_walk=0, phase=0.
//  - rst mid-phase aborts immediately; the next cycle shows the reset values.
//  - States (phase code), lamps:
//      A_GRN(0)  LA=00 LB=10
//      A_YEL(1)  LA=01 LB=10
//      RED_AB(2) LA=10 LB=10
//      B_GRN(3)  LA=10 LB=00
//      B_YEL(4)  LA=10 LB=01
//      RED_BA(5) LA=10 LB=10
//      WALK(6)   LA=10 LB=10 ped_walk=1
//  - cnt clears to 0 on the clock edge that changes state.
//  - Otherwise cnt increments on tick and saturates at 2**CNT_W-1.
//  - Transitions are evaluated only on tick=1. Let e = cnt+1 (elapsed ticks including the current one):
//      A_GRN->A_YEL when (e>=GREEN_MIN && !TA) || e>=GREEN_MAX
//      B_GRN->B_YEL when (e>=GREEN_MIN && !TB) || e>=GREEN_MAX
//      A_YEL->RED_AB and B_YEL->RED_BA when e==YELLOW_TICKS
//      RED_AB->B_GRN and RED_BA->A_GRN when e==ALLRED_TICKS (WALK diversion under CONFIGURATION)
//  - Continuous traffic on both streets alternates the greens at GREEN_MAX.
//  - A street with no traffic leaves green at exactly GREEN_MIN.
//  - tick held high runs one tick per clk. tick=0 freezes both state and cnt.
//  - TA/TB are sampled only on tick cycles. No latching: a glitch between ticks is ignored.
//  - The street order A->B->A is fixed; there is never a green on both streets.
// CONFIGURATION
//  - TLC_PED_EN defined:
//    - ped_req=1 on any cycle sets ped_pend (sticky).
//    - From RED_AB or RED_BA with ped_pend=1, the transition at e==ALLRED_TICKS goes to WALK and clears ped_pend.
//    - WALK holds PED_TICKS ticks, then goes to the green that would have followed (B_GRN after RED_AB, A_GRN after RED_BA).
//    - One extra state bit remembers which green follows.
//    - ped_req during WALK sets ped_pend again, served at the next all-red.
//  - TLC_PED_EN undefined:
//    - No WALK state; ped_req is ignored; ped_walk is tied to 0.
//    - ped_pend does not exist. The ports stay present.
// TESTING (defaults; tick=1 every 4 clk)
//  - Reset, TA=1, TB=1 -> LA=00 for 12 ticks, then 01 for 2, all-red for 1, then LB=00 for 12. The cycle repeats.
//  - TA=0 from reset -> A_GRN exits at tick 4 exactly. With TB=0 as well, B_GRN also exits at tick 4.
//  - tick held 0 for 100 clk mid-A_YEL -> state, cnt and lamps are unchanged. On resume, yellow completes its remaining tick.
//  - Assert rst for 1 clk during B_GRN at cnt=5 -> next clk shows LA=00, LB=10, phase=0, cnt=0.
//  - TLC_PED_EN, 1-clk ped_req pulse in A_GRN -> after RED_AB comes WALK: ped_walk=1 with both lamps red for 6 ticks, then B_GRN.
//  - No macro, same pulse -> RED_AB goes straight to B_GRN and ped_walk stays 0. Assert LA/LB never 11 and never both 00.

Source files
------------

// File: rtl/traffic_light_timed.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_light_timed: two-street, tick-timed lamp controller with min/max  |
// | green, yellow, all-red clearance; optional walk phase under TLC_PED_EN.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module traffic_light_timed #(
  parameter int CNT_W        = 8,
  parameter int GREEN_MIN    = 4,
  parameter int GREEN_MAX    = 12,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int PED_TICKS    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       TA,
  input  logic       TB,
  input  logic       ped_req,
  output logic [1:0] LA,
  output logic [1:0] LB,
  output logic       ped_walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5,
    WALK   = 3'd6
  } state_t;

  localparam logic [1:0]       c_green   = 2'b00;
  localparam logic [1:0]       c_yellow  = 2'b01;
  localparam logic [1:0]       c_red     = 2'b10;
  localparam logic [CNT_W:0]   c_gmin    = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0]   c_gmax    = (CNT_W+1)'(GREEN_MAX);
  localparam logic [CNT_W:0]   c_yel     = (CNT_W+1)'(YELLOW_TICKS);
  localparam logic [CNT_W:0]   c_allred  = (CNT_W+1)'(ALLRED_TICKS);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_e;

  // Elapsed ticks including the current one; one bit wider so it never wraps.
  assign w_e = {1'b0, r_cnt} + (CNT_W+1)'(1);

`ifdef TLC_PED_EN
  localparam logic [CNT_W:0] c_ped = (CNT_W+1)'(PED_TICKS);
  logic r_ped_pend;
  logic r_walk_to_b;
  logic w_enter_walk;

  assign w_enter_walk = (w_next == WALK) && (r_state != WALK);
`else
  logic w_unused;
  assign w_unused = ped_req & (PED_TICKS > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= A_GRN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (tick && (r_cnt != c_cnt_max))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef TLC_PED_EN
  // A request arriving on the very cycle WALK is entered stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ped_pend  <= 1'b0;
      r_walk_to_b <= 1'b0;
    end else begin
      r_ped_pend <= (r_ped_pend & ~w_enter_walk) | ped_req;
      if (w_enter_walk)
        r_walk_to_b <= (r_state == RED_AB);
    end
  end
`endif

  always_comb begin
    w_next = r_state;
    if (tick) begin
      case (r_state)
        A_GRN:  if ((w_e >= c_gmin && !TA) || w_e >= c_gmax) w_next = A_YEL;
        A_YEL:  if (w_e == c_yel) w_next = RED_AB;
        RED_AB: if (w_e == c_allred) begin
`ifdef TLC_PED_EN
                  w_next = r_ped_pend ? WALK : B_GRN;
`else
                  w_next = B_GRN;
`endif
                end
        B_GRN:  if ((w_e >= c_gmin && !TB) || w_e >= c_gmax) w_next = B_YEL;
        B_YEL:  if (w_e == c_yel) w_next = RED_BA;
        RED_BA: if (w_e == c_allred) begin
`ifdef TLC_PED_EN
                  w_next = r_ped_pend ? WALK : A_GRN;
`else
                  w_next = A_GRN;
`endif
                end
`ifdef TLC_PED_EN
        WALK:   if (w_e == c_ped) w_next = r_walk_to_b ? B_GRN : A_GRN;
`endif
        default: w_next = A_GRN;
      endcase
    end
  end

  always_comb begin
    LA       = c_red;
    LB       = c_red;
    ped_walk = 1'b0;
    phase    = r_state;
    case (r_state)
      A_GRN: LA = c_green;
      A_YEL: LA = c_yellow;
      B_GRN: LB = c_green;
      B_YEL: LB = c_yellow;
`ifdef TLC_PED_EN
      WALK:  ped_walk = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire
